eeprom_burst_reader: RTL
========================

// Module: eeprom_burst_reader
// PURPOSE
//  Upstream controller for the parallel read-only EEPROM in the base_conversion design.
//  Accepts a (start address, length) request and sequences ee_cs_n, ee_oe_n and ee_addr.
//  Waits a fixed access time, then captures each byte and presents it on a valid/ready stream.
//  That stream feeds the conversion datapath; one request yields a burst of consecutive bytes.
// PARAMETERS
//  ADDR_W         16  EEPROM address width
//  DATA_W          8  EEPROM data width
//  LEN_W           8  width of the request byte count
//  ACCESS_CYCLES   3  cycles ee_oe_n is held low before the byte is sampled (legal range 1..15)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       read request present
//  req_ready  out  1       block can accept a request (high only in IDLE)
//  req_addr   in   ADDR_W  first byte address
//  req_len    in   LEN_W   number of bytes to read
//  ee_cs_n    out  1       EEPROM chip select, active low
//  ee_oe_n    out  1       EEPROM output enable, active low
//  ee_addr    out  ADDR_W  EEPROM address
//  ee_data    in   DATA_W  EEPROM data; may be Z while ee_oe_n is high
//  out_valid  out  1       out_data holds a captured byte
//  out_ready  in   1       consumer accepts the byte
//  out_data   out  DATA_W  captured byte
//  out_last   out  1       qualifies out_data as the final byte of the burst
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse when a burst completes
// BEHAVIOUR
//  Reset values: req_ready=1, ee_cs_n=1, ee_oe_n=1, ee_addr=0, out_valid=0, out_data=0,
//   out_last=0, busy=0, done=0, FSM in IDLE, all counters 0. All outputs are registered.
//  FSM states: IDLE, SETUP, WAIT, RESP.
//  IDLE: a request is accepted on req_valid&&req_ready; latch req_addr into addr_q and req_len into rem_q.
//   - req_len==0: stay in IDLE; assert done next cycle; no EEPROM access.
//   - req_len!=0: go to SETUP.
//  SETUP (1 cycle): ee_cs_n=0, ee_oe_n=1, ee_addr=addr_q. Go to WAIT; load wait_cnt=ACCESS_CYCLES-1.
//  WAIT: ee_cs_n=0, ee_oe_n=0, ee_addr stable. Decrement wait_cnt each cycle.
//   - At the edge ending the cycle where wait_cnt==0: out_data<=ee_data, out_valid<=1,
//     out_last<=(rem_q==1), ee_cs_n<=1, ee_oe_n<=1; go to RESP.
//   - ee_data is sampled only at that edge, never while ee_oe_n is high.
//  RESP: hold out_data/out_last/out_valid stable until out_valid&&out_ready; EEPROM deselected.
//   On the handshake edge: out_valid<=0, rem_q<=rem_q-1, addr_q<=addr_q+1.
//   - rem_q was 1: go to IDLE and assert done for one cycle.
//   - otherwise: go to SETUP.
//  Latency: the request is accepted at edge E. out_valid is first high after edge E+1+ACCESS_CYCLES.
//   With out_ready held high, the burst rate is one byte per ACCESS_CYCLES+2 cycles.
//  Address wraps modulo 2^ADDR_W: 0xFFFF+1 = 0x0000. No error is flagged on wrap.
//  ee_addr only changes while ee_cs_n is high or in SETUP; it never changes while ee_oe_n is low.
//  req_valid is ignored while busy; a request held across a burst is taken on the first IDLE cycle.
//  done and a new accept may coincide only on a req_len==0 request.
//  Reset mid-burst: ee_cs_n/ee_oe_n go high and out_valid goes low immediately (async).
//   The burst is dropped and no done is produced.
// STRUCTURE
//  Shared package eeprom_pkg: FSM state encoding (2-bit localparams), ADDR_W/DATA_W defaults,
//   ACCESS_CYCLES default.
//  Single module, no sub-module. The wait counter and the byte counter are inline registers.
// TESTING  (bench instantiates this block plus the EEPROM model, memory[i]=i[7:0])
//  1. req_addr=0x0010, req_len=4, out_ready=1: out bytes 10,11,12,13; out_last on 13 only;
//     done one cycle after the 13 handshake; first out_valid 4 cycles after the accept.
//  2. req_addr=0xFFFE, req_len=3: ee_addr sequence FFFE, FFFF, 0000; data FE, FF, 00.
//  3. req_len=2, out_ready low 10 cycles on byte 0: out_data holds 0xXX stable with
//     ee_cs_n=ee_oe_n=1; second access starts only after the handshake.
//  4. req_len=0: no ee_cs_n activity; done pulses once; req_ready stays high.
//  5. rst_n low during WAIT of byte 2 of 5: ee_cs_n=1 and out_valid=0 same cycle;
//     no done; a new request after reset works normally.
//  6. ACCESS_CYCLES=1 and 7: ee_oe_n low for exactly 1 and 7 cycles per byte;
//     assertion that ee_data is never X/Z when sampled.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared constants and FSM encoding for the EEPROM burst reader.
package eeprom_pkg;

  localparam int unsigned ADDR_W_DEF        = 16;
  localparam int unsigned DATA_W_DEF        = 8;
  localparam int unsigned LEN_W_DEF         = 8;
  localparam int unsigned ACCESS_CYCLES_DEF = 3;

  // Wait counter is wide enough for the largest access time (15).
  localparam int unsigned WAIT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } state_e;

endpackage

// File: rtl/eeprom_burst_reader.sv
// Sequences a parallel EEPROM through a burst of consecutive byte reads and
// streams the captured bytes out on a valid/ready interface.
module eeprom_burst_reader
  import eeprom_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned LEN_W         = LEN_W_DEF,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              ee_cs_n,
  output logic              ee_oe_n,
  output logic [ADDR_W-1:0] ee_addr,
  input  logic [DATA_W-1:0] ee_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                cs_n_d, oe_n_d, out_valid_d, out_last_d, done_d;
  logic [ADDR_W-1:0]   ee_addr_d;
  logic [DATA_W-1:0]   out_data_d;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    cs_n_d      = ee_cs_n;
    oe_n_d      = ee_oe_n;
    ee_addr_d   = ee_addr;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          rem_d  = req_len;
          if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = S_SETUP;
            cs_n_d    = 1'b0;
            oe_n_d    = 1'b1;
            ee_addr_d = req_addr;
          end
        end
      end
      S_SETUP: begin
        state_d = S_WAIT;
        oe_n_d  = 1'b0;
        wait_d  = WAIT_W'(ACCESS_CYCLES - 1);
      end
      S_WAIT: begin
        // ee_data is only ever sampled here, with ee_oe_n low for the full access time.
        if (wait_q == '0) begin
          state_d     = S_RESP;
          out_data_d  = ee_data;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == LEN_W'(1));
          cs_n_d      = 1'b1;
          oe_n_d      = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rem_d       = rem_q - LEN_W'(1);
          addr_d      = addr_q + ADDR_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_SETUP;
            cs_n_d    = 1'b0;
            ee_addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; async reset deselects the EEPROM at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      ee_cs_n   <= 1'b1;
      ee_oe_n   <= 1'b1;
      ee_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      ee_cs_n   <= cs_n_d;
      ee_oe_n   <= oe_n_d;
      ee_addr   <= ee_addr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      done      <= done_d;
      busy      <= (state_d != S_IDLE);
      req_ready <= (state_d == S_IDLE);
    end
  end

endmodule
